sec32_encoder_stream: RTL

- Streaming encoder for the 32-bit single-error-correcting code used by the team's 32-bit SEC decoder.
- Takes 32-bit data words over a valid/ready interface and produces the 8 check bits through a 2-stage backpressured pipeline.
- Emits the 40-bit codeword, plus an enable strobe, for the decoder side.
- Includes one-shot fault injection so decoder correction paths can be exercised in-system.

---
 rtl/sec32_pkg.sv | 38 +++
 rtl/sec32_parity_slice.sv | 16 +
 rtl/sec32_encoder_stream.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sec32_pkg.sv
// Shared definitions for the 32-bit SEC code: widths, check-group masks,
// a reference check-bit function and the fault-injection state type.
package sec32_pkg;

    localparam int DATA_W = 32;
    localparam int CHK_W  = 8;
    localparam int CW_W   = DATA_W + CHK_W;

    // Check bit i is the even parity of (data & CHK_MASK[i]); each group has 12 bits.
    localparam logic [CHK_W-1:0][DATA_W-1:0] CHK_MASK = {
        32'h8888_F0F0,  // c7
        32'h4444_0F0F,  // c6
        32'h2222_FF00,  // c5
        32'h1111_00FF,  // c4
        32'hF0F0_8888,  // c3
        32'h0F0F_4444,  // c2
        32'hFF00_2222,  // c1
        32'h00FF_1111   // c0
    };

    // Lower half of the word feeds the first-stage partial parities.
    localparam logic [DATA_W-1:0] LO_HALF_MASK = 32'h0000_FFFF;

    typedef enum logic {
        INJ_IDLE,
        INJ_ARMED
    } inj_state_t;

    function automatic logic [CHK_W-1:0] sec32_check(input logic [DATA_W-1:0] data);
        logic [CHK_W-1:0] chk;
        chk = '0;
        for (int i = 0; i < CHK_W; i++) begin
            chk[i] = ^(data & CHK_MASK[i]);
        end
        return chk;
    endfunction

endpackage

// File: rtl/sec32_parity_slice.sv
// Combinational first-stage partial parities: the lower-half contribution of
// every check group (4-bit slice terms for c0..c3, 8-bit block terms for c4..c7).
module sec32_parity_slice
    import sec32_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CHK_W-1:0]  partial
);

    generate
        for (genvar gi = 0; gi < CHK_W; gi++) begin : g_partial
            assign partial[gi] = ^(data & CHK_MASK[gi] & LO_HALF_MASK);
        end
    endgenerate

endmodule

// File: rtl/sec32_encoder_stream.sv
// Two-stage backpressured SEC encoder: S1 holds data + lower-half partials,
// S2 folds in the upper half, applies any pending one-shot fault and drives out_*.
module sec32_encoder_stream
    import sec32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [CHK_W-1:0]    out_check,
    output logic                out_en,
    input  logic                inj_arm,
    input  logic [5:0]          inj_pos,
    output logic                inj_armed,
    output logic [CNT_W-1:0]    word_cnt,
    output logic [CNT_W-1:0]    inj_cnt
);

    localparam logic [5:0] INJ_POS_MAX = 6'(CW_W - 1);

    logic                s1_valid_reg;
    logic [DATA_W-1:0]   s1_data_reg;
    logic [CHK_W-1:0]    s1_part_reg;
    logic                s2_valid_reg;
    logic [DATA_W-1:0]   s2_data_reg;
    logic [CHK_W-1:0]    s2_check_reg;

    inj_state_t          inj_state_reg;
    logic [5:0]          inj_pos_reg;
    logic [CNT_W-1:0]    word_cnt_reg;
    logic [CNT_W-1:0]    inj_cnt_reg;

    logic                s1_adv;
    logic                s2_adv;
    logic                s1_load;
    logic                s2_load;
    logic                arm_ok;
    logic                inj_fire;
    logic                out_xfer;
    logic [CHK_W-1:0]    in_part;
    logic [CHK_W-1:0]    hi_term;
    logic [CHK_W-1:0]    check_next;
    logic [CW_W-1:0]     flip_next;
    logic [DATA_W-1:0]   data_next;

    // Handshake: each stage advances when empty or when the one after it drains.
    assign s2_adv   = ~s2_valid_reg | out_ready;
    assign s1_adv   = ~s1_valid_reg | s2_adv;
    assign in_ready = s1_adv;
    assign s1_load  = in_valid & s1_adv;
    assign s2_load  = s1_valid_reg & s2_adv;
    assign out_xfer = s2_valid_reg & out_ready;

    assign arm_ok   = inj_arm & (inj_pos <= INJ_POS_MAX);
    assign inj_fire = s2_load & (inj_state_reg == INJ_ARMED);

    sec32_parity_slice u_parity_slice (
        .data    (in_data),
        .partial (in_part)
    );

    generate
        for (genvar gi = 0; gi < CHK_W; gi++) begin : g_hi_term
            assign hi_term[gi] = ^(s1_data_reg & CHK_MASK[gi] & ~LO_HALF_MASK);
        end
    endgenerate

    assign check_next = s1_part_reg ^ hi_term;

    always_comb begin
        flip_next = '0;
        if (inj_state_reg == INJ_ARMED) begin
            flip_next[inj_pos_reg] = 1'b1;
        end
    end

    assign data_next = s1_data_reg ^ flip_next[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_part_reg  <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (s1_load) begin
                s1_data_reg <= in_data;
                s1_part_reg <= in_part;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_check_reg <= '0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s2_load) begin
                s2_data_reg  <= data_next;
                s2_check_reg <= check_next ^ flip_next[CW_W-1:DATA_W];
            end
        end
    end

    // A new arm always wins the next state; the word loaded this cycle has
    // already used the previous position via flip_next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_state_reg <= INJ_IDLE;
            inj_pos_reg   <= '0;
            inj_cnt_reg   <= '0;
        end else begin
            if (inj_fire) begin
                inj_cnt_reg <= inj_cnt_reg + 1'b1;
            end
            case (inj_state_reg)
                INJ_IDLE: begin
                    if (arm_ok) begin
                        inj_state_reg <= INJ_ARMED;
                        inj_pos_reg   <= inj_pos;
                    end
                end
                INJ_ARMED: begin
                    if (arm_ok) begin
                        inj_state_reg <= INJ_ARMED;
                        inj_pos_reg   <= inj_pos;
                    end else if (inj_fire) begin
                        inj_state_reg <= INJ_IDLE;
                    end
                end
                default: inj_state_reg <= INJ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_reg <= '0;
        end else if (out_xfer) begin
            word_cnt_reg <= word_cnt_reg + 1'b1;
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_en    = s2_valid_reg;
    assign out_data  = s2_data_reg;
    assign out_check = s2_check_reg;
    assign inj_armed = (inj_state_reg == INJ_ARMED);
    assign word_cnt  = word_cnt_reg;
    assign inj_cnt   = inj_cnt_reg;

endmodule
